// File: rtl/regfile_xfer_pkg.sv
// Shared types for the register-file transfer engine.
//   state_t   : controller states
//   DIR_READ  : cmd_dir value that streams registers out
//   DIR_WRITE : cmd_dir value that streams registers in
package regfile_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/regfile_xfer.sv
// regfile_xfer: moves a block of consecutive registers between a
// negedge-write / dual-combinational-read register file and a pair of
// valid/ready streams.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_dir, cmd_base, cmd_count direction, first address, register count
//   out_valid/out_ready/out_data/out_last   read stream
//   in_valid/in_ready/in_data    write stream
//   done, err                    one-cycle completion / rejection pulses
//   wen1, ad1, din1              register-file write port
//   ad2, ad3, dout2, dout3       register-file read ports
//
// Build option
//   REGFILE_XFER_WRAP_EN  defined: a block running past the top address
//                         wraps to 0. Undefined: such a command is
//                         rejected with an err pulse and no access.
module regfile_xfer
  import regfile_xfer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  done,
  output logic                  err,
  output logic                  wen1,
  output logic [ADDR_WIDTH-1:0] ad1,
  output logic [DATA_WIDTH-1:0] din1,
  output logic [ADDR_WIDTH-1:0] ad2,
  output logic [ADDR_WIDTH-1:0] ad3,
  input  logic [DATA_WIDTH-1:0] dout2,
  input  logic [DATA_WIDTH-1:0] dout3
);

  localparam int unsigned           DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] LIMIT   = (ADDR_WIDTH+2)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   REM_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   rem;

  logic [ADDR_WIDTH+1:0] span;
  logic                  too_long;
  logic                  bad_cmd;
  logic                  out_hs;

  // base+count computed two bits wide so 15+16 cannot overflow.
  assign span = {2'b00, cmd_base} + {1'b0, cmd_count};

`ifdef REGFILE_XFER_WRAP_EN
  assign too_long = 1'b0;
`else
  assign too_long = (span > LIMIT);
`endif

  // A count above the file depth would revisit addresses; reject it in
  // either build.
  assign bad_cmd = (cmd_count == '0) || ({1'b0, cmd_count} > LIMIT) || too_long;

  assign out_hs   = out_valid && out_ready;
  assign out_last = out_valid && (rem == REM_ONE);

  // Read addresses: ad2 fetches the first beat in LOAD, ad3 prefetches
  // the following beat so RD can sustain one beat per cycle.
  assign ad2 = ptr;
  assign ad3 = ptr + PTR_ONE;

  always_comb begin
    state_d   = state;
    cmd_ready = (state == IDLE);
    in_ready  = (state == WR);
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (bad_cmd)                 state_d = IDLE;
          else if (cmd_dir == DIR_WRITE) state_d = WR;
          else                         state_d = LOAD;
        end
      end
      LOAD: state_d = RD;
      RD:   if (out_hs && rem == REM_ONE) state_d = FIN;
      WR:   if (in_valid && rem == REM_ONE) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wen1      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ad1       <= '0;
      din1      <= '0;
      out_data  <= '0;
      ptr       <= '0;
      rem       <= '0;
    end else begin
      state <= state_d;
      wen1  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (bad_cmd) begin
              err <= 1'b1;
            end else begin
              ptr <= cmd_base;
              rem <= cmd_count;
            end
          end
        end
        LOAD: begin
          out_data  <= dout2;
          out_valid <= 1'b1;
        end
        RD: begin
          if (out_hs) begin
            if (rem > REM_ONE) begin
              out_data <= dout3;
              ptr      <= ptr + PTR_ONE;
              rem      <= rem - REM_ONE;
            end else begin
              out_valid <= 1'b0;
            end
          end
        end
        WR: begin
          if (in_valid) begin
            wen1 <= 1'b1;
            ad1  <= ptr;
            din1 <= in_data;
            ptr  <= ptr + PTR_ONE;
            rem  <= rem - REM_ONE;
          end
        end
        // done lands one cycle after FIN, i.e. after the last wen1 cycle
        // has committed on its negedge.
        FIN: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_xfer.sv
// Scoreboard bench for regfile_xfer with a negedge-write register file.
// Drivers push expected beats/writes/events into queues as stimulus is
// issued; a negedge monitor pops and compares whenever the DUT presents
// out handshakes, wen1, done or err.
module tb_regfile_xfer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int EV_R = 1, EV_W = 2, EV_E = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_dir;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          done, err, wen1;
  logic [AW-1:0] ad1, ad2, ad3;
  logic [DW-1:0] din1, dout2, dout3;

  always #5 clk = ~clk;

  regfile_xfer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .done(done), .err(err),
    .wen1(wen1), .ad1(ad1), .din1(din1),
    .ad2(ad2), .ad3(ad3), .dout2(dout2), .dout3(dout3)
  );

  // Register file the DUT drives: negedge write, combinational reads.
  logic [DW-1:0] rf [16] = '{default: 8'h00};
  always @(negedge clk) if (wen1) rf[ad1] <= din1;
  assign dout2 = rf[ad2];
  assign dout3 = rf[ad3];

  // Reference model: register contents as implied by accepted writes.
  logic [DW-1:0] ref_mem [16] = '{default: 8'h00};

  logic [DW:0]      exp_beats [$];  // {last, data}
  logic [AW+DW-1:0] exp_wr [$];     // {addr, data}
  int               exp_ev [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_wen = -10;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT output with nothing expected (cycle %0d)", nm, cyc);
  endtask

  // ---------------- monitor ----------------
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    logic [DW:0]      b;
    logic [AW+DW-1:0] w;
    int               ev;
    cyc++;
    if (stall_q && rst_n) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), int'(stall_data));
    end
    if (out_valid) begin
      if (exp_beats.size() == 0) unexpected("out_valid");
      else begin
        b = exp_beats[0];
        chk("out_last", int'(out_last), int'(b[DW]));
        if (out_ready) begin
          void'(exp_beats.pop_front());
          chk("out_data", int'(out_data), int'(b[DW-1:0]));
        end
      end
    end
    if (wen1) begin
      if (exp_wr.size() == 0) unexpected("wen1");
      else begin
        w = exp_wr.pop_front();
        chk("ad1", int'(ad1), int'(w[AW+DW-1:DW]));
        chk("din1", int'(din1), int'(w[DW-1:0]));
      end
      last_wen = cyc;
    end
    if (done) begin
      if (exp_ev.size() == 0) unexpected("done");
      else begin
        ev = exp_ev.pop_front();
        chk("done_event", ev == EV_E ? 0 : 1, 1);
        if (ev == EV_W) chk("done_after_wen", cyc - last_wen, 1);
      end
    end
    if (err) begin
      if (exp_ev.size() == 0) unexpected("err");
      else begin
        ev = exp_ev.pop_front();
        chk("err_event", ev, EV_E);
      end
    end
    stall_q    = rst_n && out_valid && !out_ready;
    stall_data = out_data;
  end

  // ---------------- drivers ----------------
  function automatic bit cmd_ok(input int base, input int count);
    bit fits;
`ifdef REGFILE_XFER_WRAP_EN
    fits = 1'b1;
`else
    fits = (base + count) <= 16;
`endif
    return (count >= 1) && (count <= 16) && fits;
  endfunction

  // Caller is 1 time unit after a posedge; returns likewise.
  task automatic issue_cmd(input bit dir, input int base, input int count, output bit ok);
    int g;
    ok        = cmd_ok(base, count);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_base  = AW'(base);
    cmd_count = (AW+1)'(count);
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 100) begin
      @(posedge clk); #1; @(negedge clk); g++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    if (!ok) exp_ev.push_back(EV_E);
    else if (dir == 1'b0) begin
      for (int i = 0; i < count; i++)
        exp_beats.push_back({i == count - 1, ref_mem[(base + i) % 16]});
      exp_ev.push_back(EV_R);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // mode 0: continuous ready, 1: toggle 1,0,1,0, 2: random
  task automatic do_read(input int base, input int count, input int mode);
    bit ok;
    int got, k;
    issue_cmd(1'b0, base, count, ok);
    if (!ok) return;
    got = 0;
    k = 0;
    while (got < count && k < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'b1;                // stray write beats must be ignored
      in_data  = 8'($urandom);
      @(negedge clk);
      if (out_valid && out_ready) got++;
      @(posedge clk); #1;
      k++;
    end
    if (got < count) chk("read_timeout", got, count);
    if (mode == 0) chk("read_cycles", k, count + 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  // data_mode 0: random, else beat i = data_mode + 0x11*i.
  // abort_at >= 0: pulse reset after that many beats were accepted.
  task automatic do_write(input int base, input int count, input int data_mode,
                          input int gaps, input int abort_at);
    bit ok;
    int g, a;
    logic [DW-1:0] d;
    issue_cmd(1'b1, base, count, ok);
    if (!ok) return;
    for (int i = 0; i < count; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_wen1", int'(wen1), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        chk("abort_done", int'(done), 0);
        @(posedge clk); #1;
        return;
      end
      if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = (data_mode == 0) ? 8'($urandom) : 8'(data_mode + 17 * i);
      a = (base + i) % 16;
      in_valid = 1'b1;
      in_data  = d;
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 50) begin
        @(posedge clk); #1; @(negedge clk); g++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      exp_wr.push_back({AW'(a), d});
      ref_mem[a] = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    exp_ev.push_back(EV_W);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_count = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen1", int'(wen1), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ad1", int'(ad1), 0);
    chk("rst_din1", int'(din1), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_ad2", int'(ad2), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Block write then read-back, continuous ready.
    do_write(3, 4, 8'h11, 0, -1);
    idle(2);
    do_read(3, 4, 0);
    idle(2);

    // Full-file read with ready toggling every cycle.
    for (int i = 0; i < 16; i++) begin end
    do_write(0, 16, 0, 0, -1);
    idle(2);
    do_read(0, 16, 1);
    idle(2);

    // Zero count: err, no access, ready again next cycle.
    begin
      bit ok;
      issue_cmd(1'b1, 5, 0, ok);
      @(negedge clk);
      chk("zero_cmd_ready", int'(cmd_ready), 1);
      chk("zero_out_valid", int'(out_valid), 0);
      chk("zero_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    idle(2);

    // Block crossing the top address.
    do_write(14, 4, 8'h51, 0, -1);
    idle(2);
    do_read(14, 4, 0);
    idle(2);

    // Reset after 2 of 4 beats: 3,4 new, 5,6 retain 0x11-pattern data.
    do_write(3, 4, 8'h11, 0, -1);
    idle(2);
    do_write(3, 4, 8'h91, 0, 2);
    idle(2);
    for (int a = 3; a <= 6; a++) chk($sformatf("abort_rf%0d", a), int'(rf[a]), int'(ref_mem[a]));
    chk("abort_rf5_old", int'(rf[5]), 8'h33);
    chk("abort_rf3_new", int'(rf[3]), 8'h91);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int base, count;
      base  = $urandom_range(0, 15);
      count = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 17) : $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 1) do_write(base, count, 0, 1, -1);
      else                           do_read(base, count, $urandom_range(0, 2));
      idle($urandom_range(0, 3));
    end

    idle(6);
    chk("left_beats", exp_beats.size(), 0);
    chk("left_writes", exp_wr.size(), 0);
    chk("left_events", exp_ev.size(), 0);
    for (int a = 0; a < 16; a++) chk($sformatf("final_rf%0d", a), int'(rf[a]), int'(ref_mem[a]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
